// File: rtl/regfile_pkg.sv
// Shared register-file definitions: FSM state encoding and the default
// geometry that the CPU top level also uses.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_t;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 16;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port: register mux, optional write-to-read bypass
// and the matching busy indication.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_sel,
  output logic [DATA_W-1:0] data,
  output logic              busy_out
);

  logic hit;
  logic rsv_hit;

  // Forward a same-cycle write; its busy clear is visible unless a new
  // reservation on the same register lands in that cycle too.
  always_comb begin
    hit      = (BYPASS != 0) && we && (wr_sel == sel);
    rsv_hit  = rsv_en && (rsv_sel == sel);
    data     = '0;
    busy_out = 1'b0;
    if (run) begin
      data     = hit ? wr_data : regs[sel];
      busy_out = (hit && !rsv_hit) ? 1'b0 : busy[sel];
    end
  end

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with busy scoreboard and a
// sequential clear engine that zeroes storage after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_sel,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     init_done
);

  rf_state_t           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                run;

  assign run = (state_q == ST_RUN);

  // Clear sequencing: walk cnt over every register, then enter RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, counter and registered init_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_done <= (state_d == ST_RUN);
    end
  end

  // Storage has no reset so it can map to RAM; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        regs[cnt_q] <= '0;
      end else if (we) begin
        regs[wr_sel] <= wr_data;
      end
    end
  end

  // Busy scoreboard; the reserve is applied last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (run) begin
      if (we) begin
        busy[wr_sel] <= 1'b0;
      end
      if (rsv_en) begin
        busy[rsv_sel] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .BYPASS  (BYPASS),
      .ADDR_W  (ADDR_W)
    ) u_port (
      .run     (run),
      .sel     (rd_sel[k*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .we      (we),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .rsv_en  (rsv_en),
      .rsv_sel (rsv_sel),
      .data    (rd_data[k*DATA_W +: DATA_W]),
      .busy_out(rd_busy[k])
    );
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-port bypassing instance and a 1-port
// non-bypassing instance share the write/reserve stimulus.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [3:0]   wr_sel;
  logic [31:0]  wr_data;
  logic         rsv_en;
  logic [3:0]   rsv_sel;
  logic [15:0]  rd_sel;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic         init_done;
  logic [31:0]  nb_data;
  logic [0:0]   nb_busy;
  logic         nb_init_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_regs [16];
  logic [15:0] m_busy;
  logic        m_run;
  logic [3:0]  m_cnt;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we(we), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_busy(rd_busy), .init_done(init_done)
  );

  regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rd_sel(rd_sel[3:0]), .rd_data(nb_data),
    .rd_busy(nb_busy), .init_done(nb_init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    rd_sel = {d, c, b, a};
  endtask

  task automatic idle();
    we = 1'b0; rsv_en = 1'b0; wr_sel = '0; wr_data = '0; rsv_sel = '0;
  endtask

  function automatic logic [31:0] exp_data(input logic [3:0] s, input bit byp);
    if (!m_run) return '0;
    if (byp && we && wr_sel == s) return wr_data;
    return m_regs[s];
  endfunction

  function automatic logic exp_busy(input logic [3:0] s, input bit byp);
    if (!m_run) return 1'b0;
    if (byp && we && wr_sel == s && !(rsv_en && rsv_sel == s)) return 1'b0;
    return m_busy[s];
  endfunction

  // One clock: push expectations for the driven inputs, pop and compare the
  // DUT outputs, advance the model, then move to the next falling edge.
  task automatic tick();
    logic [3:0] s;
    exp_t e;
    #1;
    for (int k = 0; k < 4; k++) begin
      s = rd_sel[k*4 +: 4];
      sb.push_back('{$sformatf("data%0d", k), exp_data(s, 1'b1)});
      sb.push_back('{$sformatf("busy%0d", k), {31'b0, exp_busy(s, 1'b1)}});
    end
    sb.push_back('{"nb_data", exp_data(rd_sel[3:0], 1'b0)});
    sb.push_back('{"nb_busy", {31'b0, exp_busy(rd_sel[3:0], 1'b0)}});
    sb.push_back('{"init_done", {31'b0, m_run}});
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front(); chk(e.tag, rd_data[k*32 +: 32], e.val);
      e = sb.pop_front(); chk(e.tag, {31'b0, rd_busy[k]}, e.val);
    end
    e = sb.pop_front(); chk(e.tag, nb_data, e.val);
    e = sb.pop_front(); chk(e.tag, {31'b0, nb_busy[0]}, e.val);
    e = sb.pop_front(); chk(e.tag, {31'b0, init_done}, e.val);
    if (reset) begin
      m_run = 1'b0; m_cnt = '0; m_busy = '0;
    end else if (!m_run) begin
      m_regs[m_cnt] = '0;
      if (m_cnt == 4'd15) m_run = 1'b1;
      else m_cnt = m_cnt + 4'd1;
    end else begin
      if (we) begin
        m_regs[wr_sel] = wr_data;
        m_busy[wr_sel] = 1'b0;
      end
      if (rsv_en) m_busy[rsv_sel] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned clr;
    reset = 1'b1;
    idle();
    set_rd(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy = '0; m_run = 1'b0; m_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_data0", rd_data[31:0], 32'd0);
    chk("rst_busy", {28'b0, rd_busy}, 32'd0);

    // Init: writes during CLEAR are dropped; count cycles before init_done.
    reset = 1'b0;
    we = 1'b1; wr_sel = 4'd5; wr_data = 32'd99;
    clr = 0;
    for (int i = 0; i < 40; i++) begin
      if (init_done === 1'b1) break;
      clr++;
      tick();
    end
    chk("clear_cycles", clr, 32'd16);
    idle();
    set_rd(5, 5, 0, 0);
    #1;
    chk("r5_after_init", rd_data[31:0], 32'd0);
    tick();

    // Basic write/read.
    we = 1'b1; wr_sel = 4'd3; wr_data = 32'd30; tick();
    wr_sel = 4'd10; wr_data = 32'd100; tick();
    idle();
    set_rd(3, 10, 0, 0);
    #1;
    chk("rd_r3", rd_data[31:0], 32'd30);
    chk("rd_r10", rd_data[63:32], 32'd100);
    chk("rd_busy01", {30'b0, rd_busy[1:0]}, 32'd0);
    tick();

    // Bypass versus no bypass.
    we = 1'b1; wr_sel = 4'd7; wr_data = 32'd5; tick();
    wr_data = 32'd42; set_rd(7, 0, 0, 0);
    #1;
    chk("bypass_on", rd_data[31:0], 32'd42);
    chk("bypass_off", nb_data, 32'd5);
    tick();
    idle();
    #1;
    chk("bypass_off_next", nb_data, 32'd42);
    tick();

    // Scoreboard.
    rsv_en = 1'b1; rsv_sel = 4'd4; tick();
    idle(); set_rd(4, 0, 0, 0);
    #1;
    chk("busy_after_rsv", {31'b0, rd_busy[0]}, 32'd1);
    tick();
    we = 1'b1; wr_sel = 4'd4; wr_data = 32'd77;
    #1;
    chk("busy_bypassed", {31'b0, rd_busy[0]}, 32'd0);
    chk("busy_nb_write", {31'b0, nb_busy[0]}, 32'd1);
    tick();
    idle();
    #1;
    chk("busy_cleared", {31'b0, rd_busy[0]}, 32'd0);
    chk("r4_data", rd_data[31:0], 32'd77);
    tick();
    rsv_en = 1'b1; rsv_sel = 4'd4; we = 1'b1; wr_sel = 4'd4; wr_data = 32'd55; tick();
    idle();
    #1;
    chk("rsv_wins", {31'b0, rd_busy[0]}, 32'd1);
    tick();

    // Reset mid-operation.
    rsv_en = 1'b1; rsv_sel = 4'd2; we = 1'b1; wr_sel = 4'd2; wr_data = 32'd11; tick();
    idle(); reset = 1'b1; tick();
    reset = 1'b0; set_rd(2, 2, 0, 0);
    #1;
    chk("init_drop", {31'b0, init_done}, 32'd0);
    repeat (16) tick();
    #1;
    chk("init_back", {31'b0, init_done}, 32'd1);
    chk("r2_cleared", rd_data[31:0], 32'd0);
    chk("r2_not_busy", {31'b0, rd_busy[0]}, 32'd0);
    tick();

    // All four ports on one register.
    we = 1'b1; wr_sel = 4'd9; wr_data = 32'hDEADBEEF; tick();
    idle(); set_rd(9, 9, 9, 9);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("r9_port%0d", k), rd_data[k*32 +: 32], 32'hDEADBEEF);
    tick();

    // Random traffic through the scoreboard.
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      wr_sel = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      rsv_en = 1'($urandom_range(0, 1));
      rsv_sel = 4'($urandom_range(0, 15));
      rd_sel = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd_sel[3:0] = wr_sel;
      if ($urandom_range(0, 5) == 0) rsv_sel = wr_sel;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; the successor to the fixed 16x32 dual-port register file.
- Generalised in data width, register count and read-port count.
- Adds three things the old file lacked: optional write-to-read bypass, a per-register busy scoreboard for the pipeline's hazard logic, and a sequential clear-on-reset engine so storage can map to RAM.
- Sits between decode (read/reserve) and writeback (write) in the CPU datapath.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of registers; power of 2, at least 2.
- NUM_RD, 2, number of independent read ports, 1 to 4.
- BYPASS, 1, 1 = a same-cycle write to the read register is forwarded to rd_data; 0 = the old value is returned.
- ADDR_W, $clog2(NUM_REGS), derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- wr_sel  in  ADDR_W  destination register.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  mark register rsv_sel busy (pending producer issued).
- rsv_sel  in  ADDR_W  register to reserve.
- rd_sel  in  NUM_RD*ADDR_W  read selects; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  1 = selected register has a pending write.
- init_done  out  1  high once clearing completes; file usable.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset is sampled only on rising clk. While high, the FSM goes to CLEAR, the clear counter goes to 0, all busy bits go to 0, and init_done goes to 0.
- FSM states are CLEAR and RUN.
  - CLEAR: each cycle, write 0 to register[cnt] and increment cnt.
  - When cnt == NUM_REGS-1 is written, go to RUN. This gives exactly NUM_REGS cycles after reset deasserts.
  - RUN: normal operation; init_done = 1 (registered, asserts on the first RUN cycle).
  - Reset asserted mid-CLEAR or in RUN returns to CLEAR with cnt = 0 and restarts the full sequence.
- In CLEAR:
  - we and rsv_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Reads are combinational (zero latency) from the current rd_sel.
- rd_data mux, port k:
  - If BYPASS=1, we=1 and wr_sel == rd_sel[k]: output wr_data.
  - Otherwise output register[rd_sel[k]].
- Write: on a rising edge in RUN with we=1, register[wr_sel] <= wr_data.
  - Register 0 is an ordinary register (no hardwired zero).
- Scoreboard: busy[NUM_REGS] flops.
  - rsv_en sets busy[rsv_sel].
  - we clears busy[wr_sel].
- Same-register reserve and write in the same cycle: busy ends at 1. The reserve is a new producer and wins.
- Reserve and write to different registers in the same cycle: both take effect.
- rd_busy[k]:
  - Equals busy[rd_sel[k]], with one exception.
  - If BYPASS=1 and a same-cycle write targets that register with no same-register reserve, rd_busy[k] = 0, consistent with the forwarded data.
- Multiple read ports may select the same register; each gets an identical result.
- Widths: no arithmetic beyond the ADDR_W-bit counter. The counter stops at NUM_REGS-1 and does not wrap into RUN.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state enum (ST_CLEAR, ST_RUN);
  - the default DATA_W/NUM_REGS constants reused by the CPU top level.
- One natural sub-module: regfile_rdport, a single read mux plus bypass compare. It is instantiated NUM_RD times in a generate loop.
- Storage, scoreboard and FSM stay in regfile_mp.

Test Plan:
1. Init: NUM_REGS=16. Hold reset 3 cycles, release.
   -> init_done is 0 for exactly 16 cycles, then 1.
   -> Writes attempted during CLEAR (we=1, wr_sel=5, wr_data=99) are dropped; a read of r5 after init returns 0.
2. Basic write/read: in RUN, write 30 to r3, then write 100 to r10.
   -> rd_sel0=3, rd_sel1=10 give rd_data0=30, rd_data1=100, both rd_busy=0.
3. Bypass: BYPASS=1, r7 holds 5; same cycle we=1, wr_sel=7, wr_data=42, rd_sel0=7.
   -> rd_data0=42 that cycle.
   -> With BYPASS=0, rd_data0=5 that cycle and 42 the next.
4. Scoreboard: rsv_en on r4, next cycle read r4.
   -> rd_busy0=1.
   -> Write r4 with 77; the following cycle rd_busy0=0 and rd_data0=77.
   -> Reserve and write r4 in the same cycle -> busy stays 1.
5. Reset mid-operation: reserve r2 and write r2=11, then assert reset one cycle during RUN.
   -> init_done drops the next cycle; after 16 clear cycles r2 reads 0 and rd_busy=0.
6. Port scaling: NUM_RD=4, all ports select r9 (value 0xDEADBEEF).
   -> All four rd_data slices equal 0xDEADBEEF.
